// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state codes and
// small elaboration-time helpers used by the arbiter files.
package arb_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Ceiling log2, with a minimum result of 1 so it can size a register.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    // One-hot vector with bit idx set; callers truncate it to their width.
    function automatic logic [31:0] onehot(input int idx, input int n);
        logic [31:0] result;
        result = '0;
        if (idx >= 0 && idx < n) begin
            result = 32'(1) << idx;
        end
        return result;
    endfunction

endpackage

// File: rtl/seletor_rr.sv
// Combinational round-robin selector. The search starts one position past
// ptr and wraps around. The request vector is rotated so that this start
// position lands at bit 0. A lowest-bit-first priority encoder then picks
// a requester, and its offset is mapped back to an absolute index.
module seletor_rr
    import arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH_S = 2
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [WIDTH_S-1:0] ptr,
    output logic [WIDTH_S-1:0] pick,
    output logic               found
);

    logic [2*N_REQ-1:0] req_twice;
    logic [N_REQ-1:0]   rotated;
    int                 start_idx;
    int                 offset;
    int                 sum_idx;

    assign req_twice = {req, req};

    // Rotate, priority-encode from the lowest bit, then un-rotate the winner.
    always_comb begin
        start_idx = int'(ptr) + 1;
        if (start_idx >= N_REQ) begin
            start_idx = 0;
        end
        rotated = N_REQ'(req_twice >> start_idx);
        offset  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
            end
        end
        sum_idx = start_idx + offset;
        if (sum_idx >= N_REQ) begin
            sum_idx = sum_idx - N_REQ;
        end
        pick  = WIDTH_S'(sum_idx);
        found = |req;
    end

endmodule

// File: rtl/arbitro_mux_rr.sv
// Round-robin arbiter that owns the select lines of an N:1 mux.
// Grants are one-hot and registered. Between two owners there is always
// at least one cycle in which grant is all-zero.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, an owner is
// forcibly released after MAX_HOLD cycles, and timeout pulses for one cycle.
module arbitro_mux_rr
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH_S  = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   grant,
    output logic [WIDTH_S-1:0] S,
    output logic               busy,
    output logic               timeout
);

    // Reject parameter sets that would let S address a missing requester.
    if ((1 << WIDTH_S) < N_REQ) begin : g_bad_width_s
        $error("arbitro_mux_rr: WIDTH_S too small for N_REQ");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("arbitro_mux_rr: MAX_HOLD out of range 1..255");
    end

    logic [0:0]         state;
    logic [WIDTH_S-1:0] ptr;
    logic [WIDTH_S-1:0] pick;
    logic               found;
    logic [N_REQ-1:0]   pick_grant;
    logic               owner_req;

    seletor_rr #(
        .N_REQ   (N_REQ),
        .WIDTH_S (WIDTH_S)
    ) u_seletor (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .found (found)
    );

    // The pointer also serves as the index of the current owner while in GRANT.
    assign pick_grant = N_REQ'(onehot(int'(pick), N_REQ));
    assign owner_req  = req[ptr];
    assign busy       = (state == GRANT);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;
    logic             hold_expired;

    assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign timeout      = timeout_q;

    // Hold counter: zero in IDLE so every new grant starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Arbitration FSM: grant from IDLE, release back to IDLE on drop or expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            S     <= '0;
            ptr   <= WIDTH_S'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= pick_grant;
                        S     <= pick;
                        ptr   <= pick;
                        state <= GRANT;
                    end
                end
                default: begin
                    if (!owner_req) begin
                        grant <= '0;
                        state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_expired) begin
                        grant     <= '0;
                        state     <= IDLE;
                        timeout_q <= 1'b1;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_mux_rr.sv
// Scoreboard bench for arbitro_mux_rr. The stimulus driver advances a
// behavioural model of the arbitration rules and queues the expected outputs.
// An independent monitor pops the queue one cycle later and compares.
module tb_arbitro_mux_rr;

    localparam int N_REQ    = 4;
    localparam int WIDTH_S  = 2;
    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [N_REQ-1:0]   grant;
        logic [WIDTH_S-1:0] s;
        logic               busy;
        logic               timeout;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ-1:0]   grant;
    logic [WIDTH_S-1:0] S;
    logic               busy;
    logic               timeout;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model state: owner index (-1 means none) and the last winner.
    int m_owner = -1;
    int m_last  = N_REQ - 1;
    int m_s     = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    arbitro_mux_rr #(
        .N_REQ    (N_REQ),
        .WIDTH_S  (WIDTH_S),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .S       (S),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the rules of the arbiter.
    task automatic modelStep(input logic r, input logic [N_REQ-1:0] rq);
        logic [N_REQ-1:0] sh;
        int               idx;
        m_to = 1'b0;
        if (r) begin
            m_owner = -1;
            m_last  = N_REQ - 1;
            m_s     = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (m_last + k) % N_REQ;
                sh  = rq >> idx;
                if (sh[0] && m_owner < 0) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_s     = idx;
                    m_hold  = 1;
                end
            end
        end else begin
            sh = rq >> m_owner;
            if (!sh[0]) begin
                m_owner = -1;
            end else if (TIMEOUT_ON && m_hold == MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic applyStimulus(input logic r, input logic [N_REQ-1:0] rq);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        modelStep(r, rq);
        e.grant   = (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
        e.s       = WIDTH_S'(m_s);
        e.busy    = (m_owner >= 0);
        e.timeout = m_to;
        exp_q.push_back(e);
    endtask

    // Hold all requests high, but have each owner drop for one cycle after three granted cycles.
    task automatic rrStep();
        logic [N_REQ-1:0] rq;
        rq = '1;
        if (m_owner >= 0 && m_hold == 3) begin
            rq = rq & ~(N_REQ'(1) << m_owner);
        end
        applyStimulus(1'b0, rq);
    endtask

    // Monitor: check the queued expectation and the grant invariants each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("grant", 32'(grant), 32'(e.grant));
                checkOutput("S", 32'(S), 32'(e.s));
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("timeout", 32'(timeout), 32'(e.timeout));
                checkOutput("grant_onehot", 32'($countones(grant) <= 1), 32'(1));
                checkOutput("grant_matches_S", 32'((grant == '0) || ((grant >> S) & N_REQ'(1)) != '0), 32'(1));
            end
        end
    end

    initial begin
        logic [N_REQ-1:0] rnd_req;
        int               guard;

        // Reset held with every requester asking.
        repeat (2) applyStimulus(1'b1, 4'b1111);

        // Round robin with periodic releases.
        for (int c = 0; c < 30; c++) rrStep();

        // Keep the round-robin pattern until owner 3 reaches its release point.
        guard = 0;
        while (!(m_owner == 3 && m_hold == 3) && guard < 40) begin
            rrStep();
            guard = guard + 1;
        end
        applyStimulus(1'b0, 4'b0100);
        repeat (3) applyStimulus(1'b0, 4'b0100);
        applyStimulus(1'b0, 4'b0000);
        repeat (3) applyStimulus(1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b0000);

        // Reset in the middle of a grant to owner 1.
        repeat (2) applyStimulus(1'b1, 4'b0000);
        repeat (2) applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b1, 4'b0010);
        repeat (3) applyStimulus(1'b0, 4'b0010);
        applyStimulus(1'b0, 4'b0000);

        // Long hold: exercises timeout when enabled, indefinite ownership otherwise.
        repeat (2) applyStimulus(1'b0, 4'b0000);
        repeat (60) applyStimulus(1'b0, 4'b0011);
        repeat (2) applyStimulus(1'b0, 4'b0000);

        // Random traffic with sticky requests and rare resets.
        rnd_req = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                rnd_req = N_REQ'($urandom_range(0, 15));
            end
            applyStimulus(($urandom_range(0, 63) == 0), rnd_req);
        end

        repeat (3) applyStimulus(1'b0, 4'b0000);
        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
